// File: rtl/instr_loader.sv
// instr_loader: takes a length byte followed by little-endian instruction words from a byte
// stream, writes them to instruction memory, and holds the CPU in reset until a good load completes.
module instr_loader #(
    parameter int DEPTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_data_o,
    output logic        cpu_rst_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [5:0]  count_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    logic [2:0]  r_state;
    logic [7:0]  r_n;
    logic [5:0]  r_count;
    logic [1:0]  r_bcnt;
    logic [31:0] r_word;
    logic [7:0]  w_next_cnt;
    logic        w_bad_len;

    assign w_next_cnt = {2'b00, r_count} + 8'd1;
    assign w_bad_len  = (byte_data_i == 8'd0) || ({1'b0, byte_data_i} > DEPTH_L);

    // Every output is decoded from state alone, so nothing depends combinationally on the stream.
    assign byte_ready_o = (r_state == LEN) || (r_state == DATA);
    assign busy_o       = byte_ready_o || (r_state == WRITE);
    assign im_we_o      = (r_state == WRITE);
    assign done_o       = (r_state == DONE);
    assign err_o        = (r_state == ERR);
    assign cpu_rst_n_o  = (r_state == DONE);
    assign count_o      = r_count;
    assign im_addr_o    = {24'd0, r_count, 2'b00};
    assign im_data_o    = r_word;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_n     <= 8'd0;
            r_count <= 6'd0;
            r_bcnt  <= 2'd0;
            r_word  <= 32'd0;
        end else begin
            case (r_state)
                IDLE, DONE, ERR: if (start_i) begin
                    r_state <= LEN;
                    r_count <= 6'd0;
                    r_bcnt  <= 2'd0;
                    r_word  <= 32'd0;
                end
                LEN: if (byte_valid_i) begin
                    r_n     <= byte_data_i;
                    r_state <= w_bad_len ? ERR : DATA;
                end
                DATA: if (byte_valid_i) begin
                    r_word[8*r_bcnt +: 8] <= byte_data_i;
                    r_bcnt                <= r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) r_state <= WRITE;
                end
                WRITE: begin
                    r_count <= r_count + 6'd1;
                    r_state <= (w_next_cnt == r_n) ? DONE : DATA;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed loads with a write scoreboard; expected writes are queued by the
// driver and checked by an independent monitor, including the exact cycle of each strobe.
module tb_instr_loader;
    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'd0;
    logic        byte_ready_o, im_we_o, cpu_rst_n_o, busy_o, done_o, err_o;
    logic [31:0] im_addr_o, im_data_o;
    logic [5:0]  count_o;

    instr_loader #(.DEPTH(32)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .im_we_o(im_we_o), .im_addr_o(im_addr_o),
        .im_data_o(im_data_o), .cpu_rst_n_o(cpu_rst_n_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t q[$];
    exp_t m_e;
    int n_chk = 0;
    int n_fail = 0;
    int widx = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest queued write, in the predicted cycle.
    always @(negedge clk_i) begin
        if (rst_n && im_we_o) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr_o, im_data_o);
            end else begin
                m_e = q.pop_front();
                chk("wr_addr", im_addr_o, m_e.a);
                chk("wr_data", im_data_o, m_e.d);
                chk("wr_cycle", cyc, m_e.c);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int stall);
        logic r;
        repeat (stall) begin @(posedge clk_i); #1; end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        r = 1'b0;
        for (int k = 0; k < 20 && !r; k++) begin
            @(negedge clk_i);
            r = byte_ready_o;
            @(posedge clk_i);
            #1;
        end
        byte_valid_i = 1'b0;
        chk("byte_accept", r, 1);
    endtask

    // Called right after the 4th byte's accepting edge: the strobe belongs to the next cycle.
    task automatic push_exp(input logic [31:0] w);
        q.push_back('{a: widx << 2, d: w, c: cyc});
        widx++;
    endtask

    task automatic send_word(input logic [7:0] b0, b1, b2, b3, input logic [31:0] w, input int ms);
        send_byte(b0, ms ? $urandom_range(0, ms) : 0);
        send_byte(b1, ms ? $urandom_range(0, ms) : 0);
        send_byte(b2, ms ? $urandom_range(0, ms) : 0);
        send_byte(b3, ms ? $urandom_range(0, ms) : 0);
        push_exp(w);
    endtask

    task automatic do_start(input logic [7:0] n);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        widx = 0;
        send_byte(n, 0);
    endtask

    task automatic wait_idle();
        @(negedge clk_i);
        for (int k = 0; k < 40 && busy_o; k++) @(negedge clk_i);
        chk("idle_timeout", busy_o, 0);
    endtask

    task automatic check_end(input string nm, input logic [5:0] cnt, input logic dn, input logic er, input logic cr);
        chk({nm, "_count"}, count_o, cnt);
        chk({nm, "_done"}, done_o, dn);
        chk({nm, "_err"}, err_o, er);
        chk({nm, "_cpu_rst_n"}, cpu_rst_n_o, cr);
        chk({nm, "_pending"}, q.size(), 0);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_we"}, im_we_o, 0);
        chk({nm, "_ready"}, byte_ready_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_done"}, done_o, 0);
        chk({nm, "_err"}, err_o, 0);
        chk({nm, "_cpu_rst_n"}, cpu_rst_n_o, 0);
        chk({nm, "_count"}, count_o, 0);
    endtask

    initial begin
        #3;
        check_reset_vals("rst");
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("post_rst_cpu_rst_n", cpu_rst_n_o, 0);
        @(posedge clk_i);
        #1;

        // Nominal two-word load
        do_start(8'h02);
        chk("load_busy", busy_o, 1);
        chk("load_cpu_rst_n", cpu_rst_n_o, 0);
        send_word(8'h13, 8'h00, 8'h01, 8'h20, 32'h2001_0013, 0);
        send_word(8'h23, 8'h08, 8'h22, 8'h00, 32'h0022_0823, 0);
        wait_idle();
        check_end("nominal", 6'd2, 1'b1, 1'b0, 1'b1);

        // Zero length and DEPTH+1 are both rejected
        @(posedge clk_i); #1;
        do_start(8'h00);
        wait_idle();
        check_end("len0", 6'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        do_start(8'h21);
        wait_idle();
        check_end("len33", 6'd0, 1'b0, 1'b1, 1'b0);

        // Random stalls on a three-word load
        @(posedge clk_i); #1;
        do_start(8'h03);
        send_word(8'h93, 8'h00, 8'h50, 8'h00, 32'h0050_0093, 3);
        send_word(8'h13, 8'h01, 8'hA0, 8'h00, 32'h00A0_0113, 3);
        send_word(8'hB3, 8'h81, 8'h20, 8'h00, 32'h0020_81B3, 3);
        wait_idle();
        check_end("stall", 6'd3, 1'b1, 1'b0, 1'b1);

        // Reset two bytes into the second word, then a fresh one-word load
        @(posedge clk_i); #1;
        do_start(8'h02);
        send_word(8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        chk("midrst_pending", q.size(), 0);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i); #1;
        do_start(8'h01);
        send_word(8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF, 0);
        wait_idle();
        check_end("after_rst", 6'd1, 1'b1, 1'b0, 1'b1);

        // start_i pulsed mid-word must be ignored
        @(posedge clk_i); #1;
        do_start(8'h02);
        send_word(8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201, 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        send_byte(8'h07, 0);
        send_byte(8'h08, 0);
        push_exp(32'h0807_0605);
        wait_idle();
        check_end("start_busy", 6'd2, 1'b1, 1'b0, 1'b1);

        // Full-depth load: last write lands at address 124
        @(posedge clk_i); #1;
        do_start(8'd32);
        for (int i = 0; i < 32; i++)
            send_word(8'(i), 8'(i + 1), 8'hA5, 8'h5A, {8'h5A, 8'hA5, 8'(i + 1), 8'(i)}, 0);
        wait_idle();
        check_end("full", 6'd32, 1'b1, 1'b0, 1'b1);
        chk("full_words", widx, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 32-bit instruction-memory words that can be loaded.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start_i, input, 1 bit: a level sampled each cycle that requests a new load.
REQ-005 SHALL have port byte_valid_i, input, 1 bit: the source has a byte on byte_data_i.
REQ-006 SHALL have port byte_data_i, input, 8 bits: stream byte.
REQ-007 SHALL have port byte_ready_o, output, 1 bit: the loader accepts a byte this cycle; transfer occurs when byte_valid_i && byte_ready_o.
REQ-008 SHALL have port im_we_o, output, 1 bit: instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port im_addr_o, output, 32 bits: word-aligned byte address (word index << 2).
REQ-010 SHALL have port im_data_o, output, 32 bits: assembled instruction word.
REQ-011 SHALL have port cpu_rst_n_o, output, 1 bit: active-low reset to the CPU core; low holds the CPU (PC = 0).
REQ-012 SHALL have port busy_o, output, 1 bit: a load is in progress.
REQ-013 SHALL have port done_o, output, 1 bit: the last load completed successfully.
REQ-014 SHALL have port err_o, output, 1 bit: the last load was rejected (bad length).
REQ-015 SHALL have port count_o, output, 6 bits: number of words written in the current or last load.

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-017 SHALL transition IDLE/DONE/ERR -> LEN on start_i = 1, clearing count_o, done_o, err_o and the byte counter, and driving cpu_rst_n_o = 0 in the same transition.
REQ-018 SHALL assert byte_ready_o only in LEN and DATA; it SHALL be combinational from state only, never from byte_valid_i.
REQ-019 SHALL, in LEN, latch the accepted byte as word count N.
REQ-020 SHALL go from LEN to ERR when N = 0 or N > DEPTH, and to DATA otherwise.
REQ-021 SHALL, in DATA, assemble bytes little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24]; on acceptance of the 4th byte, go to WRITE.
REQ-022 SHALL hold im_we_o = 1 for exactly the one WRITE cycle, with im_addr_o = count_o << 2 and im_data_o = assembled word, all stable in that cycle.
REQ-023 SHALL, on leaving WRITE, increment count_o by 1 and go to DONE if the new count = N, and to DATA otherwise.
REQ-024 SHALL keep im_we_o = 0 in every state other than WRITE; im_addr_o and im_data_o are don't-care when im_we_o = 0.
REQ-025 SHALL make the latency from the 4th accepted byte of a word to its write strobe exactly 1 cycle; the byte counter SHALL wrap 3 -> 0.
REQ-026 SHALL leave accumulated bytes and state unchanged in a cycle with byte_valid_i = 0 (stall); no timeout.
REQ-027 SHALL, in DONE, drive done_o = 1 and cpu_rst_n_o = 1 (the CPU runs), and hold them until the next start_i.
REQ-028 SHALL, in ERR, drive err_o = 1 and cpu_rst_n_o = 0, with no memory writes.
REQ-029 SHALL drive busy_o = 1 in LEN, DATA and WRITE.
REQ-030 SHALL ignore start_i while busy_o = 1; the load in progress is not restarted.
REQ-031 SHALL not write memory beyond word N-1; words N..DEPTH-1 are left untouched and are expected to already be zero (the CPU bench treats a zero word as end of program).

Reset
REQ-032 SHALL, on rst_n = 0 at any time including mid-load, immediately force state = IDLE, count_o = 0, byte counter = 0, assembled word = 0, im_we_o = 0, byte_ready_o = 0, busy_o = 0, done_o = 0, err_o = 0, cpu_rst_n_o = 0.
REQ-033 SHALL keep cpu_rst_n_o = 0 after reset release until a successful load reaches DONE.
REQ-034 SHALL not commit any partially assembled word when reset occurs mid-load.

Verification
REQ-035 SHALL be verified for the nominal load: start, stream 02, 13 00 01 20, 23 08 22 00 -> writes (addr 0, 0x20010013) then (addr 4, 0x00220823), count_o = 2, done_o = 1, cpu_rst_n_o = 1.
REQ-036 SHALL be verified for bad length: stream 00, then a separate load streaming 21 with DEPTH = 32 -> ERR each time, err_o = 1, no im_we_o pulse, cpu_rst_n_o = 0.
REQ-037 SHALL be verified for stalls: byte_valid_i toggled randomly during a 3-word load -> identical write sequence, each im_we_o exactly 1 cycle after its 4th byte.
REQ-038 SHALL be verified for reset mid-word: assert rst_n = 0 after 2 bytes of word 1 -> all outputs at reset values; a fresh 1-word load then writes addr 0 correctly.
REQ-039 SHALL be verified for start while busy: pulse start_i during the DATA state of a 2-word load -> load completes normally with count_o = 2.
REQ-040 SHALL be verified for a full-depth load: N = 32 -> last write at addr 124, count_o = 32, done_o = 1.
